lcd_bus_responder: RTL and testbench

Synthesizable responder for the 8-bit HD44780-style parallel LCD bus (`d`, `e`, `rs`) driven by the LCD command path. It decodes the commands and data writes the controller issues: clear display, cursor home, entry mode, set address, and character write. It keeps a 32-byte display RAM and a cursor, and drives a busy flag with command-dependent duration. It is used as the LCD stand-in for on-board loopback checks and as the bus-accurate target in simulation. A debug read port exposes display RAM contents.

---
 rtl/lcd_bus_responder.sv | 157 +++++++++++++++
 tb/tb_lcd_bus_responder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_responder.sv
// HD44780-style parallel bus responder: decodes commands and data writes into a
// 32-byte display RAM with a cursor and a command-length busy flag.
module lcd_bus_responder #(
  parameter int CMD_CYCLES   = 2000,
  parameter int CLEAR_CYCLES = 80000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       e,
  input  logic       rs,
  input  logic [7:0] d,
  output logic       busy,
  output logic [4:0] cursor,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       cmd_valid,
  output logic [8:0] cmd_code,
  output logic       overrun
);

  typedef enum logic [1:0] {IDLE, EXEC, FILL, BUSY} state_t;

  localparam int MAX_CYCLES = (CMD_CYCLES > CLEAR_CYCLES) ? CMD_CYCLES : CLEAR_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] CMD_REM   = CW'(CMD_CYCLES - 1);
  localparam logic [CW-1:0] CLEAR_REM = CW'(CLEAR_CYCLES - 1);
  localparam logic [CW-1:0] FILL_REM  = CW'(CLEAR_CYCLES - 33);
  localparam logic [CW-1:0] ONE       = CW'(1);

  logic          e_s1, e_s2, e_s3;
  logic          rs_s1, rs_s2;
  logic [7:0]    d_s1, d_s2;
  logic          fall, accept, is_clear;
  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next, exec_rem;
  logic [4:0]    fill_addr, fill_next, cursor_next;
  logic          inc, inc_next;
  logic          ram_we;
  logic [4:0]    ram_waddr;
  logic [7:0]    ram_wdata;
  logic [7:0]    ram [32];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_s1  <= 1'b0;
      e_s2  <= 1'b0;
      e_s3  <= 1'b0;
      rs_s1 <= 1'b0;
      rs_s2 <= 1'b0;
      d_s1  <= 8'h00;
      d_s2  <= 8'h00;
    end else begin
      e_s1  <= e;
      e_s2  <= e_s1;
      e_s3  <= e_s2;
      rs_s1 <= rs;
      rs_s2 <= rs_s1;
      d_s1  <= d;
      d_s2  <= d_s1;
    end
  end

  assign fall     = e_s3 & ~e_s2;
  assign accept   = fall && (state == IDLE);
  assign is_clear = !cmd_code[8] && (cmd_code[7:0] == 8'h01);

  // cnt holds the BUSY cycles still owed after EXEC (and FILL for clear)
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    fill_next   = fill_addr;
    cursor_next = cursor;
    inc_next    = inc;
    exec_rem    = CMD_REM;
    ram_we      = 1'b0;
    ram_waddr   = cursor;
    ram_wdata   = cmd_code[7:0];
    case (state)
      IDLE: begin
        if (accept) state_next = EXEC;
      end
      EXEC: begin
        if (cmd_code[8]) begin
          ram_we      = 1'b1;
          cursor_next = inc ? cursor + 5'd1 : cursor - 5'd1;
        end else if (is_clear) begin
          cursor_next = 5'd0;
          inc_next    = 1'b1;
        end else if (cmd_code[7:1] == 7'b0000001) begin
          cursor_next = 5'd0;
          exec_rem    = CLEAR_REM;
        end else if (cmd_code[7:2] == 6'b000001) begin
          inc_next = cmd_code[1];
        end else if (cmd_code[7]) begin
          cursor_next = cmd_code[4:0];
        end
        if (is_clear) begin
          state_next = FILL;
          fill_next  = 5'd0;
          cnt_next   = FILL_REM;
        end else if (exec_rem == '0) begin
          state_next = IDLE;
        end else begin
          state_next = BUSY;
          cnt_next   = exec_rem;
        end
      end
      FILL: begin
        ram_we    = 1'b1;
        ram_waddr = fill_addr;
        ram_wdata = 8'h20;
        fill_next = fill_addr + 5'd1;
        if (fill_addr == 5'd31) state_next = (cnt == '0) ? IDLE : BUSY;
      end
      BUSY: begin
        if (cnt <= ONE) state_next = IDLE;
        else            cnt_next   = cnt - ONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // busy follows the FSM one cycle late so it rises the cycle after cmd_valid
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      fill_addr <= 5'd0;
      cursor    <= 5'd0;
      inc       <= 1'b1;
      busy      <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_code  <= 9'h000;
      overrun   <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      fill_addr <= fill_next;
      cursor    <= cursor_next;
      inc       <= inc_next;
      busy      <= (state != IDLE);
      cmd_valid <= accept;
      overrun   <= fall && (state != IDLE);
      if (accept) cmd_code <= {rs_s2, d_s2};
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rd_data <= 8'h00;
    else        rd_data <= ram[rd_addr];
  end

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Bench for lcd_bus_responder: vector table of bus writes plus hand-written
// latency, overrun and reset-during-fill sequences; cmd_code via scoreboard queue.
module tb_lcd_bus_responder;

  localparam int CMD_CYCLES   = 4;
  localparam int CLEAR_CYCLES = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       e = 1'b0;
  logic       rs = 1'b0;
  logic [7:0] d = 8'h00;
  logic [4:0] rd_addr = 5'd0;
  logic       busy;
  logic [4:0] cursor;
  logic [7:0] rd_data;
  logic       cmd_valid;
  logic [8:0] cmd_code;
  logic       overrun;

  typedef struct {
    logic       rs;
    logic [7:0] d;
    int         busy_len;
    logic [4:0] cursor;
    logic [4:0] chk_addr;
    logic [7:0] chk_data;
  } vec_t;

  vec_t       vecs [13];
  logic [8:0] exp_q [$];
  logic [8:0] exp_code;
  int         n_vec = 0;
  int         n_err = 0;
  int         ovr_cnt = 0;

  lcd_bus_responder #(
    .CMD_CYCLES  (CMD_CYCLES),
    .CLEAR_CYCLES(CLEAR_CYCLES)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .e        (e),
    .rs       (rs),
    .d        (d),
    .busy     (busy),
    .cursor   (cursor),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .cmd_valid(cmd_valid),
    .cmd_code (cmd_code),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Full bus strobe: setup with e low, e high for 3 cycles, then e falls.
  task automatic apply_stimulus(input logic r, input logic [7:0] v, input bit expect_accept);
    if (expect_accept) exp_q.push_back({r, v});
    @(posedge clk);
    #1 rs = r; d = v; e = 1'b0;
    repeat (3) @(posedge clk);
    #1 e = 1'b1;
    repeat (3) @(posedge clk);
    #1 e = 1'b0;
  endtask

  task automatic measure_busy(output int len);
    int t;
    t = 0;
    len = 0;
    while (!busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    while (busy && len < 200) begin
      len++;
      @(negedge clk);
    end
  endtask

  task automatic read_ram(input logic [4:0] a, output logic [7:0] v);
    @(posedge clk);
    #1 rd_addr = a;
    @(posedge clk);
    @(negedge clk);
    v = rd_data;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (cmd_valid) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected cmd_valid", 32'd1, 32'd0);
        end else begin
          exp_code = exp_q.pop_front();
          check_output("cmd_code", 32'(cmd_code), 32'(exp_code));
        end
      end
      if (overrun) ovr_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int         len;
    int         t;
    logic [7:0] rv;

    vecs[0]  = '{1'b1, 8'h41, 4,  5'd1,  5'd0,  8'h41};
    vecs[1]  = '{1'b1, 8'h42, 4,  5'd2,  5'd1,  8'h42};
    vecs[2]  = '{1'b0, 8'h9F, 4,  5'd31, 5'd5,  8'h20};
    vecs[3]  = '{1'b1, 8'h5A, 4,  5'd0,  5'd31, 8'h5A};
    vecs[4]  = '{1'b0, 8'h04, 4,  5'd0,  5'd2,  8'h20};
    vecs[5]  = '{1'b0, 8'h80, 4,  5'd0,  5'd0,  8'h41};
    vecs[6]  = '{1'b1, 8'h33, 4,  5'd31, 5'd0,  8'h33};
    vecs[7]  = '{1'b1, 8'h34, 4,  5'd30, 5'd31, 8'h34};
    vecs[8]  = '{1'b0, 8'h06, 4,  5'd30, 5'd30, 8'h20};
    vecs[9]  = '{1'b0, 8'h03, 40, 5'd0,  5'd31, 8'h34};
    vecs[10] = '{1'b0, 8'h10, 4,  5'd0,  5'd1,  8'h42};
    vecs[11] = '{1'b0, 8'hE5, 4,  5'd5,  5'd0,  8'h33};
    vecs[12] = '{1'b1, 8'h7E, 4,  5'd6,  5'd5,  8'h7E};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("reset busy", 32'(busy), 32'd0);
    check_output("reset cursor", 32'(cursor), 32'd0);
    check_output("reset cmd_valid", 32'(cmd_valid), 32'd0);
    check_output("reset overrun", 32'(overrun), 32'd0);
    check_output("reset cmd_code", 32'(cmd_code), 32'd0);
    check_output("reset rd_data", 32'(rd_data), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Clear with exact latency: cmd_valid at the 4th falling edge, busy at the 5th.
    apply_stimulus(1'b0, 8'h01, 1'b1);
    repeat (3) @(negedge clk);
    check_output("cmd_valid early", 32'(cmd_valid), 32'd0);
    @(negedge clk);
    check_output("cmd_valid pulse", 32'(cmd_valid), 32'd1);
    check_output("busy early", 32'(busy), 32'd0);
    @(negedge clk);
    check_output("busy rise", 32'(busy), 32'd1);
    check_output("cmd_valid one cycle", 32'(cmd_valid), 32'd0);
    measure_busy(len);
    check_output("clear busy length", 32'(len), 32'(CLEAR_CYCLES));
    check_output("clear cursor", 32'(cursor), 32'd0);
    for (int a = 0; a < 32; a++) begin
      read_ram(5'(a), rv);
      check_output($sformatf("fill ram[%0d]", a), 32'(rv), 32'h20);
    end

    for (int i = 0; i < 13; i++) begin
      apply_stimulus(vecs[i].rs, vecs[i].d, 1'b1);
      measure_busy(len);
      check_output($sformatf("vec%0d busy length", i), 32'(len), 32'(vecs[i].busy_len));
      check_output($sformatf("vec%0d cursor", i), 32'(cursor), 32'(vecs[i].cursor));
      read_ram(vecs[i].chk_addr, rv);
      check_output($sformatf("vec%0d ram[%0d]", i, vecs[i].chk_addr), 32'(rv), 32'(vecs[i].chk_data));
    end

    // Data strobe landing inside a long home command must be dropped.
    ovr_cnt = 0;
    apply_stimulus(1'b0, 8'h02, 1'b1);
    apply_stimulus(1'b1, 8'h55, 1'b0);
    t = 0;
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    check_output("busy falls after home", 32'(busy), 32'd0);
    repeat (4) @(negedge clk);
    check_output("overrun pulses", 32'(ovr_cnt), 32'd1);
    check_output("overrun cursor", 32'(cursor), 32'd0);
    read_ram(5'd0, rv);
    check_output("overrun ram[0]", 32'(rv), 32'h33);

    // Reset ten cycles into the fill; the unfilled tail must survive.
    apply_stimulus(1'b0, 8'h01, 1'b1);
    t = 0;
    while (!busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    check_output("fill busy rise", 32'(busy), 32'd1);
    repeat (10) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check_output("abort busy", 32'(busy), 32'd0);
    check_output("abort cursor", 32'(cursor), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    check_output("abort cmd_code", 32'(cmd_code), 32'd0);
    apply_stimulus(1'b0, 8'h02, 1'b1);
    measure_busy(len);
    check_output("home after abort busy length", 32'(len), 32'(CLEAR_CYCLES));
    check_output("home after abort cursor", 32'(cursor), 32'd0);
    read_ram(5'd31, rv);
    check_output("partial fill ram[31]", 32'(rv), 32'h34);
    read_ram(5'd0, rv);
    check_output("partial fill ram[0]", 32'(rv), 32'h20);
    read_ram(5'd5, rv);
    check_output("partial fill ram[5]", 32'(rv), 32'h20);

    repeat (4) @(negedge clk);
    check_output("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
